sequential_divider: RTL and testbench
=====================================

SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

Interface
REQ-001 The block SHALL have the port `clk`, an input of width 1: the single clock, rising-edge active.
REQ-002 The block SHALL have the port `reset_n`, an input of width 1: asynchronous, active-low reset.
REQ-003 The block SHALL have the port `op_start`, an input of width 1: a one-cycle request to begin a division, sampled only in IDLE.
REQ-004 The block SHALL have the port `op_clear`, an input of width 1: a synchronous abort/return-to-IDLE.
REQ-005 The block SHALL have the port `dividend`, an input of width 32: the dividend operand, captured when `op_start` is accepted.
REQ-006 The block SHALL have the port `divisor`, an input of width 32: the divisor operand, captured when `op_start` is accepted.
REQ-007 The block SHALL have the port `quotient`, an output of width 32: the registered quotient.
REQ-008 The block SHALL have the port `remainder`, an output of width 32: the registered remainder.
REQ-009 The block SHALL have the port `div_by_zero`, an output of width 1: the registered divide-by-zero flag, valid while `op_done` is high.
REQ-010 The block SHALL have the port `op_done`, an output of width 1: high exactly while the block is in the DONE state.

Function
REQ-011 The block SHALL implement a three-state FSM with encoding IDLE=2'b00, CALCULATING=2'b01 and DONE=2'b10; the encoding 2'b11 SHALL return the FSM to IDLE on the next edge.
REQ-012 The FSM SHALL go from IDLE to CALCULATING when `op_start`=1 and `divisor`!=0; on that edge it SHALL capture both operands, clear the 5-bit count to 0, and clear `quotient`, `remainder` and `div_by_zero`.
REQ-013 The FSM SHALL go from IDLE to DONE when `op_start`=1 and `divisor`=0, with `quotient`=32'hFFFF_FFFF, `remainder`=`dividend` and `div_by_zero`=1, so that `op_done` rises one edge after the start.
REQ-014 Each edge in CALCULATING SHALL perform one radix-2 non-restoring step (shift the partial remainder left by one, add or subtract the divisor according to the partial remainder's sign, and shift in one quotient bit) and SHALL increment the count by one.
REQ-015 The CALCULATING edge taken with count=31 SHALL perform the final step plus the remainder correction (add the divisor back if the partial remainder is negative), SHALL load `quotient` and `remainder`, and SHALL go to DONE.
REQ-016 The latency from an accepted `op_start` edge k (nonzero divisor) to `op_done`=1 SHALL be exactly 32 edges, i.e. `op_done` is first high after edge k+32.
REQ-017 The partial-remainder datapath SHALL be 33 bits wide; the count SHALL never wrap while in CALCULATING.
REQ-018 DONE SHALL be held, with `quotient`, `remainder`, `div_by_zero` and `op_done` stable, until `op_clear`=1; the next edge SHALL then go to IDLE with `op_done`=0, and the results SHALL be held until the next accept.
REQ-019 `op_start` SHALL be ignored in CALCULATING and DONE, and operand changes after the accept edge SHALL have no effect.
REQ-020 `op_clear` SHALL have priority over `op_start` in every state: with both high in IDLE, the FSM SHALL stay in IDLE; with `op_clear` high in CALCULATING, the operation SHALL be aborted and the FSM SHALL return to IDLE, with the count at 0 and the outputs zero.
REQ-021 Back-to-back operation SHALL be possible: after a clear edge the FSM is in IDLE, and `op_start` SHALL be accepted on the following edge.

Reset
REQ-022 When `reset_n`=0, the block SHALL asynchronously force state=IDLE, count=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, `op_done`=0 and all internal datapath registers to 0, regardless of `clk`.
REQ-023 A reset asserted mid-operation (CALCULATING or DONE) SHALL abandon the operation; the block SHALL leave no trace of it and SHALL accept `op_start` on the first edge after `reset_n` returns to 1.

Configuration
REQ-024 The macro `DIVIDER_SIGNED_EN` SHALL select signed operation.
REQ-025 When `DIVIDER_SIGNED_EN` is defined, operands SHALL be treated as two's complement; the block SHALL divide the absolute values and fix up the signs on the final edge, with the quotient truncated toward zero and the remainder taking the sign of the dividend; the case -2^31 / -1 SHALL give `quotient`=32'h8000_0000 and `remainder`=0 with no flag; latency SHALL be unchanged at 32 edges.
REQ-026 When `DIVIDER_SIGNED_EN` is undefined, operands SHALL be treated as unsigned with no sign-fixup logic present.
REQ-027 Divide-by-zero behaviour (REQ-013) SHALL be identical in both configurations.

Verification
REQ-028 The bench SHALL cover this scenario: reset released, `dividend`=100 and `divisor`=7, with a one-cycle `op_start` -> `op_done` rises after exactly 32 edges with `quotient`=14, `remainder`=2 and `div_by_zero`=0.
REQ-029 The bench SHALL cover this scenario: `dividend`=32'h0000_1234 and `divisor`=0, with `op_start` -> `op_done` on the next edge with `quotient`=32'hFFFF_FFFF, `remainder`=32'h0000_1234 and `div_by_zero`=1.
REQ-030 The bench SHALL cover this scenario: `op_clear` at count=10, then `op_start` with 9/3 -> the FSM is in IDLE after the clear edge with the outputs 0, then `quotient`=3 and `remainder`=0 after 32 further edges.
REQ-031 The bench SHALL cover this scenario: `reset_n` pulsed low between clock edges at count=20 -> all outputs are immediately 0 and the state is IDLE; a subsequent 32'hFFFF_FFFF / 1 gives `quotient`=32'hFFFF_FFFF and `remainder`=0.
REQ-032 The bench SHALL cover this scenario: `op_start` re-pulsed during CALCULATING and during DONE with different operands -> the results are unaffected and `op_done` is held until `op_clear`.
REQ-033 The bench SHALL cover this scenario: with `DIVIDER_SIGNED_EN` defined, -7/2 gives `quotient`=-3 and `remainder`=-1, and 7/-2 gives `quotient`=-3 and `remainder`=1; with it undefined, 32'hFFFF_FFF9/2 gives `quotient`=32'h7FFF_FFFC and `remainder`=1.

Source files
------------

// File: rtl/sequential_divider.sv
// Radix-2 non-restoring sequential divider with 32-edge latency and divide-by-zero detection.
// Define DIVIDER_SIGNED_EN for two's-complement operation (magnitude divide plus sign fixup).
module sequential_divider (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_start,
  input  logic        op_clear,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero,
  output logic        op_done
);

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    CALCULATING = 2'b01,
    DONE        = 2'b10
  } state_e;

  state_e      state_q;
  logic [4:0]  count_q;
  logic [32:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvsr_q;
  logic [31:0] quotient_q;
  logic [31:0] remainder_q;
  logic        dbz_q;
  logic        done_q;

  logic [32:0] shift_rem;
  logic [32:0] step_rem_d;
  logic [31:0] step_quo_d;
  logic [31:0] fix_rem;
  logic [31:0] opa_mag;
  logic [31:0] opb_mag;
  logic [31:0] res_quo;
  logic [31:0] res_rem;

`ifdef DIVIDER_SIGNED_EN
  logic qneg_q;
  logic rneg_q;
`endif

  // One non-restoring step; the 33-bit modular result always lands in [-D, D).
  always_comb begin
    shift_rem  = {rem_q[31:0], quo_q[31]};
    step_rem_d = rem_q[32] ? shift_rem + {1'b0, dvsr_q} : shift_rem - {1'b0, dvsr_q};
    step_quo_d = {quo_q[30:0], ~step_rem_d[32]};
    fix_rem    = step_rem_d[32] ? step_rem_d[31:0] + dvsr_q : step_rem_d[31:0];
`ifdef DIVIDER_SIGNED_EN
    opa_mag = dividend[31] ? -dividend : dividend;
    opb_mag = divisor[31]  ? -divisor  : divisor;
    res_quo = qneg_q ? -step_quo_d : step_quo_d;
    res_rem = rneg_q ? -fix_rem    : fix_rem;
`else
    opa_mag = dividend;
    opb_mag = divisor;
    res_quo = step_quo_d;
    res_rem = fix_rem;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      count_q     <= 5'd0;
      rem_q       <= 33'd0;
      quo_q       <= 32'd0;
      dvsr_q      <= 32'd0;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (!op_clear && op_start) begin
            if (divisor == 32'd0) begin
              state_q     <= DONE;
              quotient_q  <= 32'hFFFF_FFFF;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
              done_q      <= 1'b1;
            end else begin
              state_q     <= CALCULATING;
              count_q     <= 5'd0;
              rem_q       <= 33'd0;
              quo_q       <= opa_mag;
              dvsr_q      <= opb_mag;
              quotient_q  <= 32'd0;
              remainder_q <= 32'd0;
              dbz_q       <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
              qneg_q      <= dividend[31] ^ divisor[31];
              rneg_q      <= dividend[31];
`endif
            end
          end
        end
        CALCULATING: begin
          if (op_clear) begin
            state_q     <= IDLE;
            count_q     <= 5'd0;
            rem_q       <= 33'd0;
            quo_q       <= 32'd0;
            dvsr_q      <= 32'd0;
            quotient_q  <= 32'd0;
            remainder_q <= 32'd0;
            dbz_q       <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
`endif
          end else begin
            rem_q <= step_rem_d;
            quo_q <= step_quo_d;
            if (count_q == 5'd31) begin
              state_q     <= DONE;
              count_q     <= 5'd0;
              quotient_q  <= res_quo;
              remainder_q <= res_rem;
              done_q      <= 1'b1;
            end else begin
              count_q <= count_q + 5'd1;
            end
          end
        end
        DONE: begin
          if (op_clear) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign op_done     = done_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider: a cycle-level transaction model checked every
// cycle, plus directed vectors with hand-computed results (honours DIVIDER_SIGNED_EN).
module tb_sequential_divider;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        op_start = 1'b0;
   logic        op_clear = 1'b0;
   logic [31:0] dividend = 32'd0;
   logic [31:0] divisor = 32'd0;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;
   logic        op_done;

   int testCount = 0;
   int failCount = 0;

   sequential_divider dut (
      .clk(clk),
      .reset_n(reset_n),
      .op_start(op_start),
      .op_clear(op_clear),
      .dividend(dividend),
      .divisor(divisor),
      .quotient(quotient),
      .remainder(remainder),
      .div_by_zero(div_by_zero),
      .op_done(op_done)
   );

   // 10 ns clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Reference arithmetic: plain / and %, with the signed overflow case pinned explicitly.
   function automatic logic [63:0] modelDiv(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q;
      logic [31:0] r;
`ifdef DIVIDER_SIGNED_EN
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end
`else
      q = a / b;
      r = a % b;
`endif
      return {q, r};
   endfunction

   logic        mBusy = 1'b0;
   logic        mDone = 1'b0;
   int          mLeft = 0;
   logic [31:0] mQ = 32'd0;
   logic [31:0] mR = 32'd0;
   logic        mZ = 1'b0;
   logic [63:0] mPend = 64'd0;

   // Transaction-level model: an accepted division resolves 32 edges later; clear aborts or releases.
   initial begin
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            mBusy = 1'b0; mDone = 1'b0; mLeft = 0;
            mQ = 32'd0; mR = 32'd0; mZ = 1'b0;
         end else if (op_clear) begin
            if (mBusy) begin
               mBusy = 1'b0; mLeft = 0;
               mQ = 32'd0; mR = 32'd0; mZ = 1'b0;
            end
            mDone = 1'b0;
         end else if (!mBusy && !mDone && op_start) begin
            if (divisor == 32'd0) begin
               mDone = 1'b1; mQ = 32'hFFFF_FFFF; mR = dividend; mZ = 1'b1;
            end else begin
               mBusy = 1'b1; mLeft = 32;
               mQ = 32'd0; mR = 32'd0; mZ = 1'b0;
               mPend = modelDiv(dividend, divisor);
            end
         end else if (mBusy) begin
            mLeft = mLeft - 1;
            if (mLeft == 0) begin
               mBusy = 1'b0; mDone = 1'b1;
               mQ = mPend[63:32]; mR = mPend[31:0];
            end
         end
      end
   end

   // Per-cycle comparison on the falling edge, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         testCount++;
         if (op_done !== mDone || quotient !== mQ || remainder !== mR || div_by_zero !== mZ) begin
            failCount++;
            $display("[TB] FAIL cycle@%0t: done=%0b q=%h r=%h dbz=%0b, required done=%0b q=%h r=%h dbz=%0b",
                     $time, op_done, quotient, remainder, div_by_zero, mDone, mQ, mR, mZ);
         end
      end
   end

   // Drive one cycle of control with operands, consume one edge, then drop the strobes.
   task automatic applyStimulus(input logic s, input logic c, input logic [31:0] a, input logic [31:0] b);
      op_start = s;
      op_clear = c;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      op_start = 1'b0;
      op_clear = 1'b0;
   endtask

   task automatic stepCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] q, input logic [31:0] r,
                              input logic z, input logic d);
      testCount++;
      if (quotient !== q || remainder !== r || div_by_zero !== z || op_done !== d) begin
         failCount++;
         $display("[TB] FAIL %s: q=%h r=%h dbz=%0b done=%0b, required q=%h r=%h dbz=%0b done=%0b",
                  name, quotient, remainder, div_by_zero, op_done, q, r, z, d);
      end
   endtask

   // Count edges until op_done rises, bounded; compare the count to the expected latency.
   task automatic waitDone(input string name, input int expEdges);
      int edges;
      edges = 0;
      while (!op_done && edges < 40) begin
         @(posedge clk);
         #1;
         edges++;
      end
      testCount++;
      if (!op_done || edges != expEdges) begin
         failCount++;
         $display("[TB] FAIL %s latency: %0d edges (done=%0b), required %0d edges",
                  name, edges, op_done, expEdges);
      end
   endtask

   task automatic runDivision(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] q, input logic [31:0] r);
      applyStimulus(1'b1, 1'b0, a, b);
      waitDone(name, 32);
      checkOutput(name, q, r, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 32'd0, 32'd0);
      checkOutput({name, " cleared"}, q, r, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      stepCycles(2);
      checkOutput("reset held", 32'd0, 32'd0, 1'b0, 1'b0);
      reset_n = 1'b1;
      stepCycles(1);
      checkOutput("reset released", 32'd0, 32'd0, 1'b0, 1'b0);

      runDivision("100/7", 32'd100, 32'd7, 32'd14, 32'd2);

      applyStimulus(1'b1, 1'b0, 32'h0000_1234, 32'd0);
      checkOutput("div by zero", 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 32'd0, 32'd0);
      checkOutput("div by zero cleared", 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b0);

      applyStimulus(1'b1, 1'b1, 32'd10, 32'd2);
      checkOutput("clear beats start", 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b0);

      applyStimulus(1'b1, 1'b0, 32'd50, 32'd5);
      stepCycles(10);
      applyStimulus(1'b0, 1'b1, 32'd0, 32'd0);
      checkOutput("abort at count 10", 32'd0, 32'd0, 1'b0, 1'b0);
      runDivision("9/3 back-to-back", 32'd9, 32'd3, 32'd3, 32'd0);

      applyStimulus(1'b1, 1'b0, 32'd1000, 32'd3);
      stepCycles(20);
      reset_n = 1'b0;
      #1;
      checkOutput("async reset mid-op", 32'd0, 32'd0, 1'b0, 1'b0);
      #1;
      reset_n = 1'b1;
      runDivision("FFFFFFFF/1 after reset", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);

      applyStimulus(1'b1, 1'b0, 32'd1000, 32'd7);
      stepCycles(5);
      applyStimulus(1'b1, 1'b0, 32'd55, 32'd0);
      waitDone("restart ignored in calc", 26);
      checkOutput("1000/7 unaffected", 32'd142, 32'd6, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'd20, 32'd4);
      stepCycles(3);
      checkOutput("done held", 32'd142, 32'd6, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 32'd0, 32'd0);
      checkOutput("done released", 32'd142, 32'd6, 1'b0, 1'b0);

      runDivision("5/9", 32'd5, 32'd9, 32'd0, 32'd5);
`ifdef DIVIDER_SIGNED_EN
      runDivision("-7/2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      runDivision("7/-2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
      runDivision("-2^31/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
`else
      runDivision("FFFFFFF9/2", 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1);
      runDivision("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0);
      runDivision("80000000/3", 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2);
`endif

      stepCycles(2);
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
